// File: rtl/elastic_join_buffered_pkg.sv
// Shared defaults and helpers for the buffered elastic join.
// Optional performance counters are enabled with ELASTIC_JOIN_PERF_EN.
package elastic_join_buffered_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int ELASTIC_BUF_DEPTH  = 2;

  // FIFO occupancy needs one bit more than the pointers so "full" is distinct from "empty".
  function automatic int cntBits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/elastic_join_buffered_if.sv
// Handshake bundle between N producers, the join, and one consumer.
interface elastic_join_buffered_if
  import elastic_join_buffered_pkg::*;
#(
  parameter int N_INPUTS   = 2,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);

  logic [N_INPUTS-1:0][DATA_WIDTH-1:0] data_input;
  logic [N_INPUTS-1:0]                 valid_input;
  logic [N_INPUTS-1:0]                 stop_input;
  logic [N_INPUTS-1:0][DATA_WIDTH-1:0] data_output;
  logic                                valid_output;
  logic                                stop_output;

  modport master (
    output data_input, valid_input, stop_output,
    input  stop_input, data_output, valid_output
  );

  modport slave (
    input  data_input, valid_input, stop_output,
    output stop_input, data_output, valid_output
  );

endinterface

// File: rtl/elastic_fifo.sv
// Per-channel FIFO of the elastic join; head_data is meaningful whenever empty is low.
module elastic_fifo
  import elastic_join_buffered_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int BUF_DEPTH  = ELASTIC_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = cntBits(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PW-1:0]         wrPtr_q, rdPtr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  doPush, doPop;

  assign full      = (count_q == CW'(BUF_DEPTH));
  assign empty     = (count_q == '0);
  assign doPush    = push & ~full;
  assign doPop     = pop & ~empty;
  assign head_data = mem_q[rdPtr_q];
  assign count_d   = count_q + CW'(doPush) - CW'(doPop);

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/elastic_join_buffered.sv
// N-input elastic join: per-channel FIFOs feed a registered output token.
// Defining ELASTIC_JOIN_PERF_EN adds saturating stall/starve counters.
module elastic_join_buffered
  import elastic_join_buffered_pkg::*;
#(
  parameter int N_INPUTS   = 2,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int BUF_DEPTH  = ELASTIC_BUF_DEPTH
`ifdef ELASTIC_JOIN_PERF_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input logic                   clk,
  input logic                   reset,
  elastic_join_buffered_if.slave bus
`ifdef ELASTIC_JOIN_PERF_EN
  , output logic [CNT_WIDTH-1:0] stall_count
  , output logic [CNT_WIDTH-1:0] starve_count
`endif
);

  logic [N_INPUTS-1:0]                 full, empty, accept;
  logic [N_INPUTS-1:0][DATA_WIDTH-1:0] head;
  logic [N_INPUTS-1:0][DATA_WIDTH-1:0] dataOut_q, dataOut_d;
  logic                                validOut_q, validOut_d;
  logic                                fire;

  // Backpressure depends only on reset and FIFO state, never on stop_output.
  assign bus.stop_input = {N_INPUTS{reset}} | full;
  assign accept         = bus.valid_input & ~bus.stop_input;
  assign fire           = (&(~empty)) & (~validOut_q | ~bus.stop_output);

  for (genvar g = 0; g < N_INPUTS; g++) begin : gChan
    elastic_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .BUF_DEPTH (BUF_DEPTH)
    ) uFifo (
      .clk      (clk),
      .reset    (reset),
      .push     (accept[g]),
      .push_data(bus.data_input[g]),
      .pop      (fire),
      .head_data(head[g]),
      .full     (full[g]),
      .empty    (empty[g])
    );
  end

  always_comb begin
    dataOut_d  = dataOut_q;
    validOut_d = validOut_q;
    if (fire) begin
      dataOut_d  = head;
      validOut_d = 1'b1;
    end else if (!bus.stop_output) begin
      validOut_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut_q  <= '0;
      validOut_q <= 1'b0;
    end else begin
      dataOut_q  <= dataOut_d;
      validOut_q <= validOut_d;
    end
  end

  assign bus.data_output  = dataOut_q;
  assign bus.valid_output = validOut_q;

`ifdef ELASTIC_JOIN_PERF_EN
  logic [CNT_WIDTH-1:0] stallCnt_q, stallCnt_d, starveCnt_q, starveCnt_d;

  // Starved means the join is blocked by missing operands while others back up.
  always_comb begin
    stallCnt_d  = stallCnt_q;
    starveCnt_d = starveCnt_q;
    if (validOut_q && bus.stop_output && stallCnt_q != '1)
      stallCnt_d = stallCnt_q + CNT_WIDTH'(1);
    if ((|full) && (|empty) && starveCnt_q != '1)
      starveCnt_d = starveCnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt_q  <= '0;
      starveCnt_q <= '0;
    end else begin
      stallCnt_q  <= stallCnt_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  assign stall_count  = stallCnt_q;
  assign starve_count = starveCnt_q;
`endif

endmodule

// File: tb/tb_elastic_join_buffered.sv
// Directed bench for elastic_join_buffered: a 2-channel and a 3-channel instance.
// The counter checks are compiled in when ELASTIC_JOIN_PERF_EN is defined.
module tb_elastic_join_buffered;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  elastic_join_buffered_if #(.N_INPUTS(2), .DATA_WIDTH(8)) ifA ();
  elastic_join_buffered_if #(.N_INPUTS(3), .DATA_WIDTH(8)) ifB ();

`ifdef ELASTIC_JOIN_PERF_EN
  logic [3:0]  stallA, starveA;
  logic [15:0] stallB, starveB;
`endif

  elastic_join_buffered #(
    .N_INPUTS(2), .DATA_WIDTH(8), .BUF_DEPTH(2)
`ifdef ELASTIC_JOIN_PERF_EN
    , .CNT_WIDTH(4)
`endif
  ) dutA (
    .clk  (clk),
    .reset(reset),
    .bus  (ifA)
`ifdef ELASTIC_JOIN_PERF_EN
    , .stall_count (stallA)
    , .starve_count(starveA)
`endif
  );

  elastic_join_buffered #(
    .N_INPUTS(3), .DATA_WIDTH(8), .BUF_DEPTH(2)
`ifdef ELASTIC_JOIN_PERF_EN
    , .CNT_WIDTH(16)
`endif
  ) dutB (
    .clk  (clk),
    .reset(reset),
    .bus  (ifB)
`ifdef ELASTIC_JOIN_PERF_EN
    , .stall_count (stallB)
    , .starve_count(starveB)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setA(input logic [1:0] v, input logic [7:0] d1, input logic [7:0] d0,
                      input logic so);
    ifA.valid_input   = v;
    ifA.data_input[1] = d1;
    ifA.data_input[0] = d0;
    ifA.stop_output   = so;
  endtask

  task automatic checkA(input string tag, input logic v, input logic [15:0] d);
    check({tag, "_valid"}, 64'(ifA.valid_output), 64'(v));
    if (v) check({tag, "_data"}, 64'(ifA.data_output), 64'(d));
  endtask

  initial begin
    reset = 1'b1;
    setA(2'b00, 8'h00, 8'h00, 1'b0);
    ifB.valid_input = '0;
    ifB.data_input  = '0;
    ifB.stop_output = 1'b0;

    tick();
    tick();
    check("rst_stopA", 64'(ifA.stop_input), 64'h3);
    check("rst_stopB", 64'(ifB.stop_input), 64'h7);
    check("rst_validA", 64'(ifA.valid_output), 64'h0);
    check("rst_dataA", 64'(ifA.data_output), 64'h0);
    reset = 1'b0;
    #1;
    check("post_rst_stopA", 64'(ifA.stop_input), 64'h0);
`ifdef ELASTIC_JOIN_PERF_EN
    check("rst_stall", 64'(stallA), 64'h0);
    check("rst_starve", 64'(starveA), 64'h0);
`endif

    // Operands arriving on different cycles: output two cycles after the last one.
    tick(); setA(2'b01, 8'h00, 8'h11, 1'b0);
    tick(); setA(2'b00, 8'h00, 8'h00, 1'b0);
    check("t1_c2_stop", 64'(ifA.stop_input), 64'h0);
    checkA("t1_c2", 1'b0, 16'h0);
    tick(); checkA("t1_c3", 1'b0, 16'h0);
    tick(); setA(2'b10, 8'h22, 8'h00, 1'b0);
    checkA("t1_c4", 1'b0, 16'h0);
    tick(); setA(2'b00, 8'h00, 8'h00, 1'b0);
    checkA("t1_c5", 1'b0, 16'h0);
    tick(); checkA("t1_c6", 1'b1, 16'h2211);
    tick(); checkA("t1_c7", 1'b0, 16'h0);

    // Consumer stalls for six cycles while three tokens stream in.
    tick(); setA(2'b11, 8'h81, 8'h01, 1'b1);
    tick(); setA(2'b11, 8'h82, 8'h02, 1'b1);
    check("t3_a1_stop", 64'(ifA.stop_input), 64'h0);
    tick(); setA(2'b11, 8'h83, 8'h03, 1'b1);
    checkA("t3_a2", 1'b1, 16'h8101);
    tick(); setA(2'b00, 8'h00, 8'h00, 1'b1);
    check("t3_a3_stop", 64'(ifA.stop_input), 64'h3);
    checkA("t3_a3", 1'b1, 16'h8101);
    tick(); checkA("t3_a4", 1'b1, 16'h8101);
    tick(); checkA("t3_a5", 1'b1, 16'h8101);
    check("t3_a5_stop", 64'(ifA.stop_input), 64'h3);
    tick(); setA(2'b00, 8'h00, 8'h00, 1'b0);
    checkA("t3_a6", 1'b1, 16'h8101);
    tick(); checkA("t3_a7", 1'b1, 16'h8202);
    check("t3_a7_stop", 64'(ifA.stop_input), 64'h0);
    tick(); checkA("t3_a8", 1'b1, 16'h8303);
    tick(); checkA("t3_a9", 1'b0, 16'h0);

    // Channel 0 fills while channel 1 is idle.
    tick(); setA(2'b01, 8'h00, 8'h31, 1'b0);
    tick(); setA(2'b01, 8'h00, 8'h32, 1'b0);
    tick(); setA(2'b00, 8'h00, 8'h00, 1'b0);
    check("t4_b2_stop", 64'(ifA.stop_input), 64'h1);
    checkA("t4_b2", 1'b0, 16'h0);
    tick(); setA(2'b10, 8'h41, 8'h00, 1'b0);
    checkA("t4_b3", 1'b0, 16'h0);
    tick(); setA(2'b00, 8'h00, 8'h00, 1'b0);
    check("t4_b4_stop", 64'(ifA.stop_input), 64'h1);
    checkA("t4_b4", 1'b0, 16'h0);
    tick(); checkA("t4_b5", 1'b1, 16'h4131);
    check("t4_b5_stop", 64'(ifA.stop_input), 64'h0);
    tick(); setA(2'b11, 8'h42, 8'h33, 1'b0);
    checkA("t4_b6", 1'b0, 16'h0);
    tick(); setA(2'b00, 8'h00, 8'h00, 1'b0);

    // Reset with 0x33 still buffered in channel 0 and a token on the output.
    tick(); setA(2'b00, 8'h00, 8'h00, 1'b1);
    checkA("t5_pre", 1'b1, 16'h4232);
    reset = 1'b1;
    #1;
    check("t5_rst_stop", 64'(ifA.stop_input), 64'h3);
    tick();
    check("t5_rst_valid", 64'(ifA.valid_output), 64'h0);
    check("t5_rst_data", 64'(ifA.data_output), 64'h0);
    reset = 1'b0;
    #1;
    check("t5_post_stop", 64'(ifA.stop_input), 64'h0);
    setA(2'b10, 8'h55, 8'h00, 1'b0);
    tick(); setA(2'b00, 8'h00, 8'h00, 1'b0);
    checkA("t5_c1", 1'b0, 16'h0);
    tick(); setA(2'b01, 8'h00, 8'h66, 1'b0);
    checkA("t5_c2", 1'b0, 16'h0);
    tick(); setA(2'b00, 8'h00, 8'h00, 1'b0);
    checkA("t5_c3", 1'b0, 16'h0);
    tick(); checkA("t5_c4", 1'b1, 16'h5566);
    tick(); checkA("t5_c5", 1'b0, 16'h0);

    // Three channels streaming every cycle: one token per cycle, two cycles of latency.
    for (int t = 0; t < 14; t++) begin
      tick();
      ifB.valid_input = (t < 10) ? 3'b111 : 3'b000;
      ifB.data_input  = {3{8'(t)}};
      check($sformatf("t2_stop_%0d", t), 64'(ifB.stop_input), 64'h0);
      if (t >= 2 && t < 12) begin
        check($sformatf("t2_valid_%0d", t), 64'(ifB.valid_output), 64'h1);
        check($sformatf("t2_data_%0d", t), 64'(ifB.data_output), 64'({3{8'(t - 2)}}));
      end else begin
        check($sformatf("t2_valid_%0d", t), 64'(ifB.valid_output), 64'h0);
      end
    end

`ifdef ELASTIC_JOIN_PERF_EN
    // Hold a token against a stalled consumer long enough to saturate a 4-bit counter.
    tick(); setA(2'b11, 8'hAA, 8'hBB, 1'b1);
    tick(); setA(2'b00, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    checkA("t6_hold", 1'b1, 16'hAABB);
    check("t6_stall_sat", 64'(stallA), 64'hF);
    check("t6_starve", 64'(starveA), 64'h0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
